blockchain_reader: RTL and testbench

- Read-side companion to the blockchain storage RAM.
- On request, walks stored blocks from address 0 up to the current chain length.
- Verifies each block's previous-hash link against the hash of the block before it.
- Presents each block downstream (VGA/HEX audit view) over a valid/ready handshake, then reports chain integrity.

---
 rtl/blockchain_pkg.sv | 24 ++
 rtl/blockchain_reader_if.sv | 24 ++
 rtl/blockchain_reader_link_checker.sv | 70 +++++++
 rtl/blockchain_reader.sv | 158 +++++++++++++++
 tb/tb_blockchain_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blockchain_pkg.sv
// Shared definitions for the blockchain RAM word layout and the read-side audit FSM.
// The writer side uses the same field constants.
package blockchain_pkg;

    localparam int HASH_W        = 8;
    localparam int PREV_HASH_MSB = 63;
    localparam int PREV_HASH_LSB = 56;
    localparam int HASH_MSB      = 55;
    localparam int HASH_LSB      = 48;
    localparam int BAL_MSB       = 47;
    localparam int BAL_LSB       = 0;

    // A block is two hash bytes followed by the balances field.
    localparam int BLOCK_W = 2 * HASH_W + (BAL_MSB - BAL_LSB + 1);

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_PRESENT,
        RD_FINISH
    } reader_state_e;

endpackage

// File: rtl/blockchain_reader_if.sv
// RAM read port and downstream block-presentation handshake of the blockchain reader.
// master = reader side, slave = RAM/consumer side.
interface blockchain_reader_if #(
    parameter int ADDR_W = 5
);
    logic                               rd_en;
    logic [ADDR_W-1:0]                  rd_addr;
    logic [blockchain_pkg::BLOCK_W-1:0] rd_data;
    logic                               blk_valid;
    logic                               blk_ready;
    logic [ADDR_W-1:0]                  blk_index;
    logic [blockchain_pkg::BLOCK_W-1:0] blk_data;
    logic                               blk_link_ok;

    modport master (
        output rd_en, rd_addr, blk_valid, blk_index, blk_data, blk_link_ok,
        input  rd_data, blk_ready
    );

    modport slave (
        input  rd_en, rd_addr, blk_valid, blk_index, blk_data, blk_link_ok,
        output rd_data, blk_ready
    );
endinterface

// File: rtl/blockchain_reader_link_checker.sv
// Previous-hash link checker: holds the expected prev_hash and the audit error record.
// BLOCK_READER_HALT_ON_ERROR_EN: err_count saturates at 1.
module block_link_checker
    import blockchain_pkg::*;
#(
    parameter int                ADDR_W       = 5,
    parameter logic [HASH_W-1:0] GENESIS_PREV = 8'h00
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                load_genesis,
    input  logic                check,
    input  logic                advance,
    input  logic [ADDR_W-1:0]   idx,
    input  logic [2*HASH_W-1:0] link_fields,
    output logic                link_ok,
    output logic                chain_ok,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_bad
);
    logic [HASH_W-1:0] prev_hash_q;
    logic [HASH_W-1:0] pending_hash_q;
    logic              chain_ok_q;
    logic [ADDR_W:0]   err_count_q;
    logic [ADDR_W:0]   err_count_d;
    logic [ADDR_W-1:0] first_bad_q;

    assign link_ok = (link_fields[2*HASH_W-1:HASH_W] == prev_hash_q);

`ifdef BLOCK_READER_HALT_ON_ERROR_EN
    assign err_count_d = (ADDR_W+1)'(1);
`else
    assign err_count_d = err_count_q + 1'b1;
`endif

    // The stored hash becomes the expected link only once the block is handed downstream.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            prev_hash_q    <= GENESIS_PREV;
            pending_hash_q <= '0;
            chain_ok_q     <= 1'b1;
            err_count_q    <= '0;
            first_bad_q    <= '0;
        end else if (load_genesis) begin
            prev_hash_q    <= GENESIS_PREV;
            chain_ok_q     <= 1'b1;
            err_count_q    <= '0;
            first_bad_q    <= '0;
        end else begin
            if (check) begin
                pending_hash_q <= link_fields[HASH_W-1:0];
                if (!link_ok) begin
                    err_count_q <= err_count_d;
                    chain_ok_q  <= 1'b0;
                    if (chain_ok_q) begin
                        first_bad_q <= idx;
                    end
                end
            end
            if (advance) begin
                prev_hash_q <= pending_hash_q;
            end
        end
    end

    assign chain_ok  = chain_ok_q;
    assign err_count = err_count_q;
    assign first_bad = first_bad_q;

endmodule

// File: rtl/blockchain_reader.sv
// Audit reader: walks the blockchain RAM, checks every prev-hash link, presents each block.
// BLOCK_READER_HALT_ON_ERROR_EN: the audit stops after the first failing block is transferred.
module blockchain_reader
    import blockchain_pkg::*;
#(
    parameter int                ADDR_W       = 5,
    parameter int                RD_LATENCY   = 1,
    parameter logic [HASH_W-1:0] GENESIS_PREV = 8'h00
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [ADDR_W:0]     chain_len,
    blockchain_reader_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                chain_ok,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_bad
);
    localparam int                LAT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LATENCY);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(1) << ADDR_W;

    reader_state_e       state_q;
    logic [ADDR_W:0]     idx_q;
    logic [ADDR_W:0]     idx_d;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     len_d;
    logic [LAT_W-1:0]    lat_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                blk_valid_q;
    logic [ADDR_W-1:0]   blk_index_q;
    logic [BLOCK_W-1:0]  blk_data_q;
    logic                blk_link_ok_q;
    logic                busy_q;
    logic                done_q;

    logic start_go;
    logic capture;
    logic transfer;
    logic link_ok;
    logic halt_now;

    assign start_go = (state_q == RD_IDLE) && start;
    assign capture  = (state_q == RD_WAIT) && (lat_q == LAT_LAST);
    assign transfer = (state_q == RD_PRESENT) && blk_valid_q && bus.blk_ready;
    assign idx_d    = idx_q + 1'b1;
    assign len_d    = (chain_len > DEPTH) ? DEPTH : chain_len;

`ifdef BLOCK_READER_HALT_ON_ERROR_EN
    assign halt_now = !blk_link_ok_q;
`else
    assign halt_now = 1'b0;
`endif

    block_link_checker #(
        .ADDR_W       (ADDR_W),
        .GENESIS_PREV (GENESIS_PREV)
    ) u_link_checker (
        .clock        (clock),
        .resetn       (resetn),
        .load_genesis (start_go),
        .check        (capture),
        .advance      (transfer),
        .idx          (idx_q[ADDR_W-1:0]),
        .link_fields  (bus.rd_data[PREV_HASH_MSB:HASH_LSB]),
        .link_ok      (link_ok),
        .chain_ok     (chain_ok),
        .err_count    (err_count),
        .first_bad    (first_bad)
    );

    // rd_en is registered, so the RAM sees the read in the first WAIT cycle and
    // the latency count starts there; idx_q is one bit wider so addresses never wrap.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= RD_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            lat_q         <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            blk_valid_q   <= 1'b0;
            blk_index_q   <= '0;
            blk_data_q    <= '0;
            blk_link_ok_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        len_q <= len_d;
                        idx_q <= '0;
                        if (len_d == '0) begin
                            state_q <= RD_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_ISSUE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= idx_q[ADDR_W-1:0];
                    lat_q     <= '0;
                    state_q   <= RD_WAIT;
                end
                RD_WAIT: begin
                    rd_en_q <= 1'b0;
                    if (capture) begin
                        blk_data_q    <= bus.rd_data;
                        blk_index_q   <= idx_q[ADDR_W-1:0];
                        blk_link_ok_q <= link_ok;
                        blk_valid_q   <= 1'b1;
                        state_q       <= RD_PRESENT;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                RD_PRESENT: begin
                    if (transfer) begin
                        blk_valid_q <= 1'b0;
                        idx_q       <= idx_d;
                        if ((idx_d == len_q) || halt_now) begin
                            state_q <= RD_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                RD_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= RD_IDLE;
                end
                default: begin
                    state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.blk_valid   = blk_valid_q;
    assign bus.blk_index   = blk_index_q;
    assign bus.blk_data    = blk_data_q;
    assign bus.blk_link_ok = blk_link_ok_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_blockchain_reader.sv
// Self-checking bench for blockchain_reader: chain table, hand-written corner sequences
// and randomized audits checked against a chain-walking reference model.
`timescale 1ns/1ps
module tb_blockchain_reader;
    import blockchain_pkg::*;

    localparam int                ADDR_W = 5;
    localparam int                LAT    = 2;
    localparam logic [HASH_W-1:0] GEN    = 8'h00;
    localparam int                DEPTH  = 1 << ADDR_W;
`ifdef BLOCK_READER_HALT_ON_ERROR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    typedef struct {
        int len;
        int bad1;
        int bad2;
        bit expOk;
        int expErr;
        int expFirst;
        int expXfers;
    } vec_t;

    logic              clock = 1'b0;
    logic              resetn;
    logic              start;
    logic [ADDR_W:0]   chainLen;
    logic              busy;
    logic              done;
    logic              chainOk;
    logic [ADDR_W:0]   errCount;
    logic [ADDR_W-1:0] firstBad;

    blockchain_reader_if #(.ADDR_W(ADDR_W)) bus ();

    blockchain_reader #(
        .ADDR_W       (ADDR_W),
        .RD_LATENCY   (LAT),
        .GENESIS_PREV (GEN)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .chain_len (chainLen),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .chain_ok  (chainOk),
        .err_count (errCount),
        .first_bad (firstBad)
    );

    always #5 clock = ~clock;

    // RAM model: data appears LAT cycles after the cycle that carries rd_en.
    logic [BLOCK_W-1:0] mem  [DEPTH];
    logic [BLOCK_W-1:0] pipe [LAT];
    always @(posedge clock) begin
        if (bus.rd_en) pipe[0] <= mem[bus.rd_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rd_data = pipe[LAT-1];

    int total = 0;
    int bad = 0;
    int rdCount = 0;
    int doneCount = 0;
    int cycle = 0;
    int rdCycle = 0;
    int validCycle = 0;
    int doneCycle = 0;
    logic validPrev = 1'b0;
    logic [ADDR_W-1:0]  xIdx  [$];
    logic [BLOCK_W-1:0] xData [$];
    logic               xLink [$];

    always @(posedge clock) cycle <= cycle + 1;

    // Monitor sampling on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (bus.blk_valid && bus.blk_ready) begin
            xIdx.push_back(bus.blk_index);
            xData.push_back(bus.blk_data);
            xLink.push_back(bus.blk_link_ok);
        end
        if (bus.rd_en) begin
            rdCount <= rdCount + 1;
            rdCycle <= cycle;
        end
        if (bus.blk_valid && !validPrev) validCycle <= cycle;
        validPrev <= bus.blk_valid;
        if (done) begin
            doneCount <= doneCount + 1;
            doneCycle <= cycle;
        end
    end

    int mXfers;
    int mErr;
    int mFirst;
    bit mOk;
    bit mLink [DEPTH];
    int rd0;
    int d0;
    int x0;
    int startCycle;
    bit timedOut;

    function automatic logic [HASH_W-1:0] goodHash(input int i);
        case (i)
            0:       return 8'hA1;
            1:       return 8'h5C;
            2:       return 8'hE7;
            default: return 8'(i * 29 + 51);
        endcase
    endfunction

    task automatic buildChain();
        logic [HASH_W-1:0] prev;
        logic [HASH_W-1:0] h;
        prev = GEN;
        for (int i = 0; i < DEPTH; i++) begin
            h = goodHash(i);
            mem[i] = {prev, h, 16'(i), 32'($urandom)};
            prev = h;
        end
    endtask

    task automatic corrupt(input int i);
        mem[i][PREV_HASH_MSB:PREV_HASH_LSB] = mem[i][PREV_HASH_MSB:PREV_HASH_LSB] ^ 8'h01;
    endtask

    // Reference: walk the chain comparing each prev field with the previous stored hash.
    task automatic refAudit(input int len);
        int n;
        logic [HASH_W-1:0] prev;
        n = (len > DEPTH) ? DEPTH : len;
        prev = GEN;
        mXfers = 0;
        mErr = 0;
        mFirst = 0;
        foreach (mLink[i]) mLink[i] = 1'b0;
        for (int i = 0; i < n; i++) begin
            mLink[i] = (mem[i][PREV_HASH_MSB:PREV_HASH_LSB] == prev);
            mXfers++;
            if (!mLink[i]) begin
                if (mErr == 0) mFirst = i;
                mErr++;
            end
            prev = mem[i][HASH_MSB:HASH_LSB];
            if (HALT && !mLink[i]) break;
        end
        mOk = (mErr == 0);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic startPulse(input int len);
        rd0 = rdCount;
        d0 = doneCount;
        x0 = xIdx.size();
        @(posedge clock); #1;
        start = 1'b1;
        chainLen = (ADDR_W+1)'(len);
        startCycle = cycle;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input bit randReady, input bit noisyLen);
        if (noisyLen) chainLen = (ADDR_W+1)'($urandom_range(0, 2 * DEPTH - 1));
        timedOut = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (doneCount != d0) begin
                timedOut = 1'b0;
                break;
            end
            bus.blk_ready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clock); #1;
        end
    endtask

    task automatic applyStimulus(input int len, input bit randReady, input bit noisyLen);
        startPulse(len);
        waitDone(randReady, noisyLen);
    endtask

    task automatic waitValid(input int idx, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.blk_valid && bus.blk_index == ADDR_W'(idx)) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic checkAudit(input string tag, input int expX, input bit expOk, input int expErr, input int expFirst);
        int n;
        n = xIdx.size() - x0;
        checkOutput({tag, "_timeout"}, 64'(timedOut), 64'd0);
        checkOutput({tag, "_xfers"}, 64'(n), 64'(expX));
        checkOutput({tag, "_reads"}, 64'(rdCount - rd0), 64'(expX));
        checkOutput({tag, "_done"}, 64'(doneCount - d0), 64'd1);
        checkOutput({tag, "_ok"}, 64'(chainOk), 64'(expOk));
        checkOutput({tag, "_err"}, 64'(errCount), 64'(expErr));
        if (!expOk) checkOutput({tag, "_first"}, 64'(firstBad), 64'(expFirst));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        for (int k = 0; k < n && k < mXfers; k++) begin
            checkOutput({tag, "_idx"}, 64'(xIdx[x0+k]), 64'(k));
            checkOutput({tag, "_data"}, xData[x0+k], mem[k]);
            checkOutput({tag, "_link"}, 64'(xLink[x0+k]), 64'(mLink[k]));
        end
    endtask

    initial begin
        vec_t vecs [8];
        int len;
        int r0;
        bit stable;
        logic [BLOCK_W-1:0] holdData;
        logic [ADDR_W-1:0]  holdIdx;

        vecs[0] = '{3,  -1, -1, 1'b1, 0, 0, 3};
        vecs[1] = '{4,   2, -1, 1'b0, 1, 2, HALT ? 3 : 4};
        vecs[2] = '{0,  -1, -1, 1'b1, 0, 0, 0};
        vecs[3] = '{1,  -1, -1, 1'b1, 0, 0, 1};
        vecs[4] = '{2,   0, -1, 1'b0, 1, 0, HALT ? 1 : 2};
        vecs[5] = '{4,   1,  3, 1'b0, HALT ? 1 : 2, 1, HALT ? 2 : 4};
        vecs[6] = '{33, -1, -1, 1'b1, 0, 0, 32};
        vecs[7] = '{32, 31, -1, 1'b0, 1, 31, 32};

        resetn = 1'b0;
        start = 1'b0;
        chainLen = '0;
        bus.blk_ready = 1'b0;
        buildChain();
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_chain_ok", 64'(chainOk), 64'd1);
        checkOutput("rst_err", 64'(errCount), 64'd0);
        checkOutput("rst_first", 64'(firstBad), 64'd0);
        checkOutput("rst_valid", 64'(bus.blk_valid), 64'd0);
        checkOutput("rst_rd_en", 64'(bus.rd_en), 64'd0);
        checkOutput("rst_blk_data", bus.blk_data, 64'd0);
        resetn = 1'b1;

        for (int v = 0; v < 8; v++) begin
            buildChain();
            if (vecs[v].bad1 >= 0) corrupt(vecs[v].bad1);
            if (vecs[v].bad2 >= 0) corrupt(vecs[v].bad2);
            refAudit(vecs[v].len);
            applyStimulus(vecs[v].len, 1'b0, 1'b0);
            checkAudit($sformatf("vec%0d", v), vecs[v].expXfers, vecs[v].expOk,
                       vecs[v].expErr, vecs[v].expFirst);
        end

        // Empty chain: done right after start, no RAM access.
        buildChain();
        refAudit(0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("empty_done_lat", 64'((doneCycle - startCycle) <= 2), 64'd1);
        checkOutput("empty_reads", 64'(rdCount - rd0), 64'd0);

        // Latency: blk_valid rises LAT+1 sample cycles after the rd_en cycle.
        refAudit(1);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("lat_capture", 64'(validCycle - rdCycle), 64'(LAT + 1));
        checkAudit("lat", 1, 1'b1, 0, 0);

        // Backpressure on block 1 for 7 cycles.
        buildChain();
        refAudit(3);
        bus.blk_ready = 1'b0;
        startPulse(3);
        waitValid(0, "bp0");
        bus.blk_ready = 1'b1;
        @(posedge clock); #1;
        bus.blk_ready = 1'b0;
        waitValid(1, "bp1");
        holdData = bus.blk_data;
        holdIdx = bus.blk_index;
        r0 = rdCount;
        stable = 1'b1;
        repeat (7) begin
            @(posedge clock); #1;
            if (!bus.blk_valid || bus.blk_data !== holdData || bus.blk_index !== holdIdx) stable = 1'b0;
        end
        checkOutput("bp_stable", 64'(stable), 64'd1);
        checkOutput("bp_no_read", 64'(rdCount - r0), 64'd0);
        checkOutput("bp_data", holdData, mem[1]);
        waitDone(1'b0, 1'b0);
        checkAudit("bp", 3, 1'b1, 0, 0);

        // Start while busy is ignored.
        refAudit(3);
        startPulse(3);
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1;
        chainLen = (ADDR_W+1)'(1);
        @(posedge clock); #1;
        start = 1'b0;
        waitDone(1'b0, 1'b0);
        checkAudit("ignore", 3, 1'b1, 0, 0);

        // Reset while block 1 is presented: no done, results back to reset values.
        buildChain();
        corrupt(0);
        bus.blk_ready = 1'b0;
        startPulse(3);
        waitValid(0, "rst0");
        bus.blk_ready = 1'b1;
        @(posedge clock); #1;
        bus.blk_ready = 1'b0;
        waitValid(1, "rst1");
        checkOutput("rst_pre_ok", 64'(chainOk), 64'd0);
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_valid", 64'(bus.blk_valid), 64'd0);
        checkOutput("rst_mid_ok", 64'(chainOk), 64'd1);
        checkOutput("rst_mid_err", 64'(errCount), 64'd0);
        d0 = doneCount;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("rst_no_done", 64'(doneCount - d0), 64'd0);
        buildChain();
        refAudit(3);
        applyStimulus(3, 1'b0, 1'b0);
        checkAudit("reaudit", 3, 1'b1, 0, 0);

        // Randomized chains, lengths, corruptions and ready patterns.
        for (int r = 0; r < 20; r++) begin
            buildChain();
            len = $urandom_range(0, DEPTH + 2);
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 3) == 0) corrupt(i);
            end
            refAudit(len);
            applyStimulus(len, 1'b1, 1'b1);
            checkAudit($sformatf("rnd%0d", r), mXfers, mOk, mErr, mFirst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
